// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch sequencer, the instruction memory and
//   the decoder: instruction word layout, the halt encoding and the
//   sequencer state type.
//
//   Instruction word (9 bits):
//     [8:6] opcode   [5:3] reg1   [2:0] reg2
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int INSTR_BITS = 9;
  localparam int OPCODE_MSB = 8;
  localparam int OPCODE_LSB = 6;
  localparam int REG1_MSB   = 5;
  localparam int REG1_LSB   = 3;
  localparam int REG2_MSB   = 2;
  localparam int REG2_LSB   = 0;

  localparam int OPCODE_BITS = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int REG_BITS    = REG1_MSB - REG1_LSB + 1;

  typedef logic [INSTR_BITS-1:0]  instr_t;
  typedef logic [OPCODE_BITS-1:0] opcode_t;
  typedef logic [REG_BITS-1:0]    reg_idx_t;

  // All-ones word terminates the program.
  localparam instr_t HALT_WORD = 9'b111_111_111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Field extraction helpers shared with the decoder.
  function automatic opcode_t get_opcode(input instr_t instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic reg_idx_t get_reg1(input instr_t instr);
    return instr[REG1_MSB:REG1_LSB];
  endfunction

  function automatic reg_idx_t get_reg2(input instr_t instr);
    return instr[REG2_MSB:REG2_LSB];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles the sequencer's control, branch and instruction-memory signals.
//
//   master : top-level control + decode/branch logic + instruction memory
//            (drives start/start_addr/stall/branch_*/instr)
//   slave  : fetch_sequencer (drives pc and the status outputs)
//
//   Signals:
//     start, start_addr        program launch request and entry address
//     stall                    freeze the sequencer this cycle
//     branch_taken/_target     redirect for the current instruction
//     instr                    word read from instruction memory at pc
//     pc                       address presented to instruction memory
//     instr_valid, running     execution status
//     done, wrapped            sticky program status
//     retired_count            saturating retired-instruction count
// ---------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int PC_BITS  = 12,
  parameter int CNT_BITS = 16
);
  import fetch_pkg::*;

  logic                start;
  logic [PC_BITS-1:0]  start_addr;
  logic                stall;
  logic                branch_taken;
  logic [PC_BITS-1:0]  branch_target;
  instr_t              instr;

  logic [PC_BITS-1:0]  pc;
  logic                instr_valid;
  logic                running;
  logic                done;
  logic [CNT_BITS-1:0] retired_count;
  logic                wrapped;

  modport master (
    output start, start_addr, stall, branch_taken, branch_target, instr,
    input  pc, instr_valid, running, done, retired_count, wrapped
  );

  modport slave (
    input  start, start_addr, stall, branch_taken, branch_target, instr,
    output pc, instr_valid, running, done, retired_count, wrapped
  );

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//
//   Ports:
//     clk      system clock
//     reset    asynchronous active-high reset (count -> 0)
//     i_clr    synchronous clear, wins over i_en
//     i_en     count one event this cycle
//     o_count  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == '1);

  // NOTE: state in clocked processes is always assigned with <= so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_at_max) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Owns the program counter. Presents pc to an async-read instruction
//   memory, inspects the returned word in the same cycle and decides the
//   next pc: stall (hold) > halt (stop, hold pc) > branch > pc+1.
//
//   Ports:
//     clk     system clock, all state on rising edge
//     reset   asynchronous active-high reset
//     bus     fetch_sequencer_if.slave (control, branch, memory, status)
//
//   Status:
//     running       state is RUN
//     instr_valid   RUN and not stalled (the word at pc retires this cycle)
//     done          halted, held until the next start
//     retired_count instructions retired since last start, saturating
//     wrapped       sticky: sequential increment went past all-ones
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int                             PC_BITS   = 12,
  parameter int                             CNT_BITS  = 16,
  parameter logic [fetch_pkg::INSTR_BITS-1:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.slave    bus
);

  import fetch_pkg::fetch_state_t, fetch_pkg::IDLE, fetch_pkg::RUN,
         fetch_pkg::DONE;

  localparam logic [PC_BITS-1:0] PC_ONE = PC_BITS'(1);

  fetch_state_t       r_state;
  fetch_state_t       w_next_state;
  logic [PC_BITS-1:0] r_pc;
  logic [PC_BITS-1:0] w_next_pc;
  logic               r_wrapped;
  logic               w_next_wrapped;
  logic               w_cnt_clr;
  logic               w_cnt_en;
  logic               w_is_halt;
  logic [PC_BITS-1:0] w_pc_inc;
  logic               w_pc_at_max;

  assign w_is_halt   = (bus.instr == HALT_WORD);
  assign w_pc_inc    = r_pc + PC_ONE;
  assign w_pc_at_max = (r_pc == '1);

  // -------------------------------------------------------------------------
  // State / PC registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_wrapped <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_wrapped <= w_next_wrapped;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / next-pc logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a hold/idle default first so no
    // path leaves a signal unassigned and no latch is inferred.
    w_next_state   = r_state;
    w_next_pc      = r_pc;
    w_next_wrapped = r_wrapped;
    w_cnt_clr      = 1'b0;
    w_cnt_en       = 1'b0;

    unique case (r_state)
      IDLE, DONE: begin
        // Stall and branch are meaningless outside RUN; only start matters.
        if (bus.start) begin
          w_next_state   = RUN;
          w_next_pc      = bus.start_addr;
          w_next_wrapped = 1'b0;
          w_cnt_clr      = 1'b1;
        end
      end

      RUN: begin
        // start is deliberately ignored here: no mid-program restart.
        if (bus.stall) begin
          // hold everything
        end else if (w_is_halt) begin
          // Halt beats a simultaneous branch; pc stays on the halt word.
          w_next_state = DONE;
          w_cnt_en     = 1'b1;
        end else if (bus.branch_taken) begin
          w_next_pc = bus.branch_target;
          w_cnt_en  = 1'b1;
        end else begin
          w_next_pc = w_pc_inc;
          w_cnt_en  = 1'b1;
          // Only a sequential step over the top counts as a wrap; a branch
          // to address 0 does not.
          if (w_pc_at_max) begin
            w_next_wrapped = 1'b1;
          end
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Retired-instruction counter
  // -------------------------------------------------------------------------
  sat_counter #(
    .WIDTH (CNT_BITS)
  ) u_retired_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (bus.retired_count)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.pc          = r_pc;
  assign bus.running     = (r_state == RUN);
  assign bus.done        = (r_state == DONE);
  assign bus.instr_valid = (r_state == RUN) && !bus.stall;
  assign bus.wrapped     = r_wrapped;

endmodule
